// File: rtl/uart_tx_unit.sv
// uart_tx_unit: asynchronous serial transmitter, start + 8 data bits (LSB first)
// + optional parity + 1 stop bit, with bit periods fixed for a 50 MHz clock.
module uart_tx_unit (
  input  logic       clock,
  input  logic       reset,
  input  logic       send,
  input  logic [7:0] data_in,
  input  logic [1:0] parity_type,
  input  logic [1:0] baud_rate,
  output logic       data_tx,
  output logic       busy,
  output logic       done
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  function automatic logic [14:0] bit_last_f(input logic [1:0] baud);
    logic [14:0] last_v;
    case (baud)
      2'b00:   last_v = 15'd20832;
      2'b01:   last_v = 15'd10416;
      2'b10:   last_v = 15'd5207;
      2'b11:   last_v = 15'd2603;
      default: last_v = 15'd20832;
    endcase
    return last_v;
  endfunction

  function automatic logic parity_bit_f(input logic [7:0] d, input logic [1:0] ptype);
    logic p_v;
    if (ptype == 2'b01) p_v = ~^d;
    else                p_v = ^d;
    return p_v;
  endfunction

  function automatic logic parity_en_f(input logic [1:0] ptype);
    return (ptype == 2'b01) || (ptype == 2'b10);
  endfunction

  state_t      state_r, state_s;
  logic [14:0] cnt_r, cnt_s;
  logic [2:0]  idx_r, idx_s;
  logic [7:0]  data_r, data_s;
  logic [1:0]  par_r, par_s;
  logic [1:0]  baud_r, baud_s;
  logic        tx_r, tx_s;
  logic        busy_r, busy_s;
  logic        done_r, done_s;
  logic        bit_end_s;
  logic        accept_s;

  // Next-state and next-output logic; a new frame may be accepted in IDLE or on
  // the final stop-bit edge so held send gives gapless back-to-back frames.
  always_comb begin
    state_s   = state_r;
    cnt_s     = cnt_r;
    idx_s     = idx_r;
    tx_s      = tx_r;
    busy_s    = busy_r;
    done_s    = 1'b0;
    bit_end_s = (cnt_r == bit_last_f(baud_r));
    accept_s  = send && ((state_r == ST_IDLE) || ((state_r == ST_STOP) && bit_end_s));
    data_s    = accept_s ? data_in     : data_r;
    par_s     = accept_s ? parity_type : par_r;
    baud_s    = accept_s ? baud_rate   : baud_r;

    case (state_r)
      ST_IDLE: begin
        cnt_s  = 15'd0;
        tx_s   = 1'b1;
        busy_s = 1'b0;
      end
      ST_START: begin
        if (bit_end_s) begin
          state_s = ST_DATA;
          cnt_s   = 15'd0;
          idx_s   = 3'd0;
          tx_s    = data_r[0];
        end else begin
          cnt_s = cnt_r + 15'd1;
        end
      end
      ST_DATA: begin
        if (bit_end_s) begin
          cnt_s = 15'd0;
          if (idx_r == 3'd7) begin
            if (parity_en_f(par_r)) begin
              state_s = ST_PARITY;
              tx_s    = parity_bit_f(data_r, par_r);
            end else begin
              state_s = ST_STOP;
              tx_s    = 1'b1;
            end
          end else begin
            idx_s = idx_r + 3'd1;
            tx_s  = data_r[idx_r + 3'd1];
          end
        end else begin
          cnt_s = cnt_r + 15'd1;
        end
      end
      ST_PARITY: begin
        if (bit_end_s) begin
          state_s = ST_STOP;
          cnt_s   = 15'd0;
          tx_s    = 1'b1;
        end else begin
          cnt_s = cnt_r + 15'd1;
        end
      end
      ST_STOP: begin
        if (bit_end_s) begin
          done_s  = 1'b1;
          state_s = ST_IDLE;
          cnt_s   = 15'd0;
          tx_s    = 1'b1;
          busy_s  = 1'b0;
        end else begin
          cnt_s = cnt_r + 15'd1;
        end
      end
      default: begin
        state_s = ST_IDLE;
        cnt_s   = 15'd0;
        tx_s    = 1'b1;
        busy_s  = 1'b0;
      end
    endcase

    if (accept_s) begin
      state_s = ST_START;
      cnt_s   = 15'd0;
      idx_s   = 3'd0;
      tx_s    = 1'b0;
      busy_s  = 1'b1;
    end else begin
      idx_s = idx_s;
    end
  end

  // State, counters, latched frame parameters and registered outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
      cnt_r   <= 15'd0;
      idx_r   <= 3'd0;
      data_r  <= 8'd0;
      par_r   <= 2'd0;
      baud_r  <= 2'd0;
      tx_r    <= 1'b1;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      idx_r   <= idx_s;
      data_r  <= data_s;
      par_r   <= par_s;
      baud_r  <= baud_s;
      tx_r    <= tx_s;
      busy_r  <= busy_s;
      done_r  <= done_s;
    end
  end

  assign data_tx = tx_r;
  assign busy    = busy_r;
  assign done    = done_r;

endmodule

// File: tb/tb_uart_tx_unit.sv
// Scoreboard bench for uart_tx_unit: stimulus queues hand-computed line bit
// sequences, a negedge monitor checks every cycle of each frame against them.
module tb_uart_tx_unit;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       send = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic [1:0] parity_type = 2'b00;
  logic [1:0] baud_rate = 2'b00;
  logic       data_tx, busy, done;

  uart_tx_unit dut (
    .clock(clock), .reset(reset), .send(send), .data_in(data_in),
    .parity_type(parity_type), .baud_rate(baud_rate),
    .data_tx(data_tx), .busy(busy), .done(done)
  );

  always #10 clock = ~clock;

  typedef struct {
    logic [10:0] bits;
    int          nb;
    int          n;
    string       name;
  } frame_t;

  frame_t exp_q[$];
  int errors = 0;
  int checks = 0;
  int idle_bad = 0;

  task automatic push_frame(input logic [10:0] bits, input int nb, input int n, input string name);
    frame_t f;
    f.bits = bits;
    f.nb   = nb;
    f.n    = n;
    f.name = name;
    exp_q.push_back(f);
  endtask

  task automatic check1(input string name, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %b, expected %b", name, act, req);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic wait_done(input string name, input int limit);
    int k;
    k = 0;
    while (done !== 1'b1 && k < limit) begin
      tick(1);
      k++;
    end
    check1(name, done, 1'b1);
  endtask

  // Monitor: frame starts when busy rises, every cycle is compared with the expected bit.
  frame_t cur;
  bit   active = 1'b0;
  bit   rogue = 1'b0;
  bit   bad = 1'b0;
  int   t = 0;
  int   bad_t = 0;
  logic bad_tx, bad_busy, bad_done, bad_exp, bad_exp_done;

  always @(negedge clock) begin
    bit   end_edge;
    bit   chained;
    logic exp_bit;
    logic exp_done;
    end_edge = 1'b0;
    chained  = 1'b0;
    if (reset) begin
      active = 1'b0;
      rogue  = 1'b0;
    end else begin
      if (active && t == cur.nb * cur.n) begin
        checks++;
        if (done !== 1'b1) begin
          errors++;
          $display("FAIL %s done_edge: done=%b at cycle %0d, expected 1", cur.name, done, t);
        end
        active   = 1'b0;
        end_edge = 1'b1;
        chained  = (busy === 1'b1);
      end
      if (!active) begin
        if (busy === 1'b1) begin
          if (!rogue) begin
            if (exp_q.size() == 0) begin
              checks++;
              errors++;
              rogue = 1'b1;
              $display("FAIL unexpected_frame: busy=1 with no frame expected");
            end else begin
              cur    = exp_q.pop_front();
              active = 1'b1;
              t      = 0;
              bad    = 1'b0;
            end
          end
        end else begin
          rogue = 1'b0;
          if (!end_edge && (data_tx !== 1'b1 || done !== 1'b0)) idle_bad++;
        end
      end
      if (active) begin
        exp_bit  = cur.bits[t / cur.n];
        exp_done = (chained && t == 0);
        if (!bad && (data_tx !== exp_bit || busy !== 1'b1 || done !== exp_done)) begin
          bad          = 1'b1;
          bad_t        = t;
          bad_tx       = data_tx;
          bad_busy     = busy;
          bad_done     = done;
          bad_exp      = exp_bit;
          bad_exp_done = exp_done;
        end
        if (t % cur.n == cur.n - 1) begin
          checks++;
          if (bad) begin
            errors++;
            $display("FAIL %s bit%0d: cycle %0d data_tx=%b busy=%b done=%b, expected data_tx=%b busy=1 done=%b",
                     cur.name, t / cur.n, bad_t, bad_tx, bad_busy, bad_done, bad_exp, bad_exp_done);
          end
          bad = 1'b0;
        end
        t++;
      end
    end
  end

  initial begin
    // Power-on reset values and idle line.
    tick(3);
    check1("rst_data_tx", data_tx, 1'b1);
    check1("rst_busy", busy, 1'b0);
    check1("rst_done", done, 1'b0);
    reset = 1'b0;
    tick(3);
    check1("idle_data_tx", data_tx, 1'b1);
    check1("idle_busy", busy, 1'b0);
    check1("idle_done", done, 1'b0);

    // Reset asserted mid-cycle with send high: no frame may start.
    #4;
    reset = 1'b1;
    send = 1'b1;
    data_in = 8'h35;
    parity_type = 2'b01;
    baud_rate = 2'b11;
    #1;
    check1("rsthold_data_tx", data_tx, 1'b1);
    check1("rsthold_busy", busy, 1'b0);
    check1("rsthold_done", done, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick(1);
      check1("rsthold_cyc_data_tx", data_tx, 1'b1);
      check1("rsthold_cyc_busy", busy, 1'b0);
    end
    send = 1'b0;
    reset = 1'b0;
    tick(2);

    // 9600 odd 0x35, aborted by reset in the middle of data bit 1.
    data_in = 8'h35;
    parity_type = 2'b01;
    baud_rate = 2'b10;
    push_frame(11'b11001101010, 11, 5208, "f9600_odd_35");
    send = 1'b1;
    tick(1);
    send = 1'b0;
    tick(5208 * 2 + 300 - 1);
    #5;
    reset = 1'b1;
    #1;
    check1("abort_data_tx", data_tx, 1'b1);
    check1("abort_busy", busy, 1'b0);
    check1("abort_done", done, 1'b0);
    tick(2);
    reset = 1'b0;
    tick(5);

    // 19200 even 0x35 full frame, with an ignored send and input changes mid-frame.
    data_in = 8'h35;
    parity_type = 2'b10;
    baud_rate = 2'b11;
    push_frame(11'b10001101010, 11, 2604, "f19200_even_35");
    send = 1'b1;
    tick(1);
    send = 1'b0;
    tick(10000);
    data_in = 8'h00;
    parity_type = 2'b00;
    baud_rate = 2'b00;
    send = 1'b1;
    tick(1);
    send = 1'b0;
    tick(17000);

    // Back-to-back: send held high across the done edge, 0xA5 without parity.
    data_in = 8'hA5;
    parity_type = 2'b00;
    baud_rate = 2'b11;
    push_frame(11'b01101001010, 10, 2604, "f19200_none_A5");
    send = 1'b1;
    wait_done("done_first_frame", 2000);
    send = 1'b0;
    check1("b2b_busy", busy, 1'b1);
    check1("b2b_start_bit", data_tx, 1'b0);
    tick(1);
    wait_done("done_second_frame", 27000);
    tick(5);

    // 2400 with parity code 11 (none), 0xFF: start bit width, then reset.
    data_in = 8'hFF;
    parity_type = 2'b11;
    baud_rate = 2'b00;
    push_frame(11'b01111111110, 10, 20833, "f2400_none_FF");
    send = 1'b1;
    tick(1);
    send = 1'b0;
    tick(20833 + 100);
    check1("f2400_bit1_level", data_tx, 1'b1);
    #5;
    reset = 1'b1;
    #1;
    check1("abort2_data_tx", data_tx, 1'b1);
    tick(2);
    reset = 1'b0;
    tick(5);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL frames_outstanding: got %0d, expected 0", exp_q.size());
    end
    checks++;
    if (idle_bad != 0) begin
      errors++;
      $display("FAIL idle_line: %0d idle cycles with data_tx!=1 or done!=0, expected 0", idle_bad);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
